// File: rtl/execute_hazard_ctrl_pkg.sv
// exe_ctrl_pkg: shared types and constants for the Execute-stage hazard
// controller.
//   fwd_sel_t      - operand forward select (RF / Writeback / Memory)
//   md_state_t     - mul/div sequencer state
//   RESULT_SRC_MEM - ResultSrc encoding for loads (data memory)
//   is_load()      - true when a ResultSrc value selects data memory
package exe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam int unsigned CNT_W = 4;

  function automatic logic is_load(input logic [1:0] result_src);
    return result_src == RESULT_SRC_MEM;
  endfunction

endpackage

// File: rtl/execute_hazard_ctrl_if.sv
// execute_hazard_ctrl_if: bundle of pipeline-side hazard inputs and the
// controller's forward/stall/flush outputs.
//   master - pipeline datapath (drives register ids and stage controls)
//   slave  - hazard controller (drives forward selects, stalls, flushes)
interface execute_hazard_ctrl_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       RegWriteM;
  logic       RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic       MulDivE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic       MulDivDoneE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, MulDivDoneE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, MulDivDoneE
  );
endinterface

// File: rtl/execute_hazard_ctrl_forward_sel.sv
// forward_sel: combinational forward select for one Execute operand.
//   rs        - source register of the operand in Execute
//   rdm/rdw   - destination registers in Memory / Writeback
//   regwritem/regwritew - those stages write the register file
//   sel       - FWD_M, FWD_W or FWD_RF; Memory wins over Writeback,
//               x0 is never forwarded
module forward_sel
  import exe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rdm,
  input  logic [4:0] rdw,
  input  logic       regwritem,
  input  logic       regwritew,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_RF;
    if (regwritem && (rdm != 5'd0) && (rdm == rs)) begin
      sel = FWD_M;
    end else if (regwritew && (rdw != 5'd0) && (rdw == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/execute_hazard_ctrl.sv
// execute_hazard_ctrl: Execute-stage hazard and sequencing controller.
//   clk, reset - single clock, synchronous active-high reset
//   hz (slave) - register ids / stage controls in; ForwardAE/BE,
//                StallF/D/E, FlushD/E/M and MulDivDoneE out
// A mul/div occupies Execute for MULDIV_LAT cycles (1..16). While it runs,
// Execute is held and bubbles are inserted into Memory.
module execute_hazard_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  execute_hazard_ctrl_if.slave hz
);

  localparam bit MULTI = (MULDIV_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    MULTI ? CNT_W'(MULDIV_LAT - 2) : '0;

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  fwd_sel_t         fwd_a, fwd_b;
  logic             lw_stall;
  logic             md_last;
  logic             md_stall;

  forward_sel u_fwd_a (
    .rs        (hz.Rs1E),
    .rdm       (hz.RdM),
    .rdw       (hz.RdW),
    .regwritem (hz.RegWriteM),
    .regwritew (hz.RegWriteW),
    .sel       (fwd_a)
  );

  forward_sel u_fwd_b (
    .rs        (hz.Rs2E),
    .rdm       (hz.RdM),
    .rdw       (hz.RdW),
    .regwritem (hz.RegWriteM),
    .regwritew (hz.RegWriteW),
    .sel       (fwd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The first cycle of an op is spent in IDLE, so BUSY counts the remaining
  // MULDIV_LAT-1 cycles down from MULDIV_LAT-2 to 0.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (hz.MulDivE && MULTI) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    md_last  = (state == BUSY) && (cnt == '0);
    md_stall = hz.MulDivE && MULTI && !md_last;
    lw_stall = is_load(hz.ResultSrcE) && (hz.RdE != 5'd0) &&
               ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  end

  assign hz.ForwardAE   = fwd_a;
  assign hz.ForwardBE   = fwd_b;
  assign hz.StallF      = lw_stall || md_stall;
  assign hz.StallD      = lw_stall || md_stall;
  assign hz.StallE      = md_stall;
  assign hz.FlushM      = md_stall;
  assign hz.FlushD      = hz.PCSrcE;
  // A held Execute instruction must not be wiped by a Decode load-use bubble.
  assign hz.FlushE      = hz.PCSrcE || (lw_stall && !md_stall);
  assign hz.MulDivDoneE = md_last || (hz.MulDivE && !MULTI);

endmodule
